// File: rtl/fifo_bram_writer_pkg.sv
// Shared definitions for the FIFO-to-BRAM writer: FIFO entry width and drain FSM states.
package fifo_bram_writer_pkg;

    // 64-bit sample word plus its packet-end flag in bit 64.
    localparam int ENTRY_W = 65;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_bram_writer_sync_fifo_65.sv
// Register-based synchronous FIFO holding 65-bit entries, first-word-fall-through read.
module sync_fifo_65
    import fifo_bram_writer_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [8:0]         count,
    output logic               full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic               push_ok;
    logic               pop_ok;
    logic [8:0]         count_next;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok    = push && !full;
    assign pop_ok     = pop && (count != 9'd0);
    assign count_next = count + {8'd0, push_ok} - {8'd0, pop_ok};
    assign dout       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 9'd0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            full  <= (count_next == 9'(DEPTH));
        end
    end

endmodule

// File: rtl/fifo_bram_writer.sv
// Buffers 64-bit samples in a FIFO and drains them as little-endian 32-bit word pairs into BRAM
// Port A, publishing a packet-aligned write pointer for software.
module fifo_bram_writer
    import fifo_bram_writer_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_DEPTH_WORDS = 16384,
    parameter int FIFO_DEPTH       = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    // fifo_write_en acts as valid with an implicit ready of !fifo_full; an entry offered
    // while fifo_full is high is discarded, there is no back-pressure wait.
    input  logic                       fifo_write_en,
    input  logic [63:0]                fifo_write_data,
    input  logic                       fifo_packet_end_flag,
    output logic                       fifo_full,
    output logic [8:0]                 fifo_count,
    output logic [BRAM_ADDR_WIDTH-3:0] current_bram_address,
    output logic                       bram_clk,
    output logic                       bram_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din,
    output logic                       bram_en,
    output logic [3:0]                 bram_we,
    output drain_state_e               debug_state
);

    localparam int WA_W = BRAM_ADDR_WIDTH - 2;
    localparam logic [WA_W-1:0] WP_LAST = WA_W'(BRAM_DEPTH_WORDS - 2);

    drain_state_e       state;
    drain_state_e       state_next;
    logic [WA_W-1:0]    wp;
    logic [WA_W-1:0]    wp_next;
    logic [ENTRY_W-1:0] head;
    logic               push_ok;
    logic               pop;
    logic [8:0]         count_after_pop;

    assign bram_clk    = clk;
    assign bram_rst    = rst;
    assign debug_state = state;

    assign push_ok         = fifo_write_en && !fifo_full;
    assign pop             = (state == ST_WR_HI);
    assign count_after_pop = fifo_count - 9'd1 + {8'd0, push_ok};
    assign wp_next         = (wp == WP_LAST) ? '0 : wp + WA_W'(2);

    sync_fifo_65 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_write_en),
        .pop   (pop),
        .din   ({fifo_packet_end_flag, fifo_write_data}),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WR_HI chains straight into WR_LO so back-to-back entries leave no idle cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fifo_count != 9'd0) state_next = ST_WR_LO;
            ST_WR_LO: state_next = ST_WR_HI;
            ST_WR_HI: state_next = (count_after_pop != 9'd0) ? ST_WR_LO : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp                   <= '0;
            current_bram_address <= '0;
            bram_addr            <= '0;
            bram_din             <= '0;
            bram_en              <= 1'b0;
            bram_we              <= 4'h0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= 4'h0;
            case (state)
                ST_WR_LO: begin
                    bram_en   <= 1'b1;
                    bram_we   <= 4'hF;
                    bram_addr <= {wp, 2'b00};
                    bram_din  <= head[31:0];
                end
                ST_WR_HI: begin
                    bram_en   <= 1'b1;
                    bram_we   <= 4'hF;
                    bram_addr <= {wp[WA_W-1:1], 1'b1, 2'b00};
                    bram_din  <= head[63:32];
                    wp        <= wp_next;
                    // Publish only once the last word of a packet is on its way to BRAM.
                    if (head[64]) begin
                        current_bram_address <= wp_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_bram_writer.sv
// Bench for fifo_bram_writer: two instances (full-size BRAM and an 8-word BRAM) share stimulus
// and are checked against a cycle-level scoreboard plus directed hand-computed checks.
module tb_fifo_bram_writer;
    import fifo_bram_writer_pkg::*;

    localparam int FD = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [63:0] wdata = 64'd0;
    logic        flag = 1'b0;

    logic         full_o   [2];
    logic [8:0]   count_o  [2];
    logic [13:0]  commit_o [2];
    logic         bclk_o   [2];
    logic         brst_o   [2];
    logic [15:0]  addr_o   [2];
    logic [31:0]  din_o    [2];
    logic         en_o     [2];
    logic [3:0]   we_o     [2];
    drain_state_e dbg_o    [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_bram_writer u_dut_main (
        .clk(clk), .rst(rst), .fifo_write_en(we), .fifo_write_data(wdata),
        .fifo_packet_end_flag(flag), .fifo_full(full_o[0]), .fifo_count(count_o[0]),
        .current_bram_address(commit_o[0]), .bram_clk(bclk_o[0]), .bram_rst(brst_o[0]),
        .bram_addr(addr_o[0]), .bram_din(din_o[0]), .bram_en(en_o[0]), .bram_we(we_o[0]),
        .debug_state(dbg_o[0])
    );

    fifo_bram_writer #(.BRAM_DEPTH_WORDS(8)) u_dut_wrap (
        .clk(clk), .rst(rst), .fifo_write_en(we), .fifo_write_data(wdata),
        .fifo_packet_end_flag(flag), .fifo_full(full_o[1]), .fifo_count(count_o[1]),
        .current_bram_address(commit_o[1]), .bram_clk(bclk_o[1]), .bram_rst(brst_o[1]),
        .bram_addr(addr_o[1]), .bram_din(din_o[1]), .bram_en(en_o[1]), .bram_we(we_o[1]),
        .debug_state(dbg_o[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? 16384 : 8;
    endfunction

    // ---------------- scoreboard ----------------
    logic [64:0]  exp_q[$];
    logic [64:0]  head;
    int           m_cnt = 0;
    drain_state_e m_st = ST_IDLE;
    drain_state_e st_old;
    int           cnt_old;
    int           m_wp[2] = '{0, 0};
    int           m_commit[2] = '{0, 0};
    logic         push_acc;
    logic         hi;
    logic         cap_we, cap_flag, cap_rst;
    logic [63:0]  cap_data;

    always @(posedge clk) begin
        cap_we   = we;
        cap_data = wdata;
        cap_flag = flag;
        cap_rst  = rst;
    end

    always @(negedge clk) begin
        if (cap_rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_st  = ST_IDLE;
            for (int i = 0; i < 2; i++) begin
                m_wp[i] = 0;
                m_commit[i] = 0;
                check($sformatf("rst_en[%0d]", i), 64'(en_o[i]), 64'd0);
                check($sformatf("rst_we[%0d]", i), 64'(we_o[i]), 64'd0);
                check($sformatf("rst_addr[%0d]", i), 64'(addr_o[i]), 64'd0);
                check($sformatf("rst_din[%0d]", i), 64'(din_o[i]), 64'd0);
            end
        end else begin
            st_old   = m_st;
            cnt_old  = m_cnt;
            push_acc = cap_we && (cnt_old != FD);
            hi       = (st_old == ST_WR_HI);
            head     = (exp_q.size() > 0) ? exp_q[0] : 65'd0;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("en[%0d]", i), 64'(en_o[i]), 64'(st_old != ST_IDLE));
                if (st_old != ST_IDLE) begin
                    check($sformatf("we[%0d]", i), 64'(we_o[i]), 64'hF);
                    check($sformatf("addr[%0d]", i), 64'(addr_o[i]), 64'((m_wp[i] + int'(hi)) * 4));
                    check($sformatf("din[%0d]", i), 64'(din_o[i]), hi ? 64'(head[63:32]) : 64'(head[31:0]));
                end else begin
                    check($sformatf("we_idle[%0d]", i), 64'(we_o[i]), 64'd0);
                end
            end
            case (st_old)
                ST_IDLE:  m_st = (cnt_old > 0) ? ST_WR_LO : ST_IDLE;
                ST_WR_LO: m_st = ST_WR_HI;
                default:  m_st = ((cnt_old - 1 + int'(push_acc)) > 0) ? ST_WR_LO : ST_IDLE;
            endcase
            if (hi && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    m_wp[i] = (m_wp[i] + 2) % depth_of(i);
                    if (head[64]) m_commit[i] = m_wp[i];
                end
            end
            if (push_acc) exp_q.push_back({cap_flag, cap_data});
            m_cnt = cnt_old + int'(push_acc) - int'(hi);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("count[%0d]", i), 64'(count_o[i]), 64'(m_cnt));
            check($sformatf("full[%0d]", i), 64'(full_o[i]), 64'(m_cnt == FD));
            check($sformatf("commit[%0d]", i), 64'(commit_o[i]), 64'(m_commit[i]));
            check($sformatf("state[%0d]", i), 64'(dbg_o[i]), 64'(m_st));
            check($sformatf("bram_rst[%0d]", i), 64'(brst_o[i]), 64'(rst));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        we = 1'b0;
        flag = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push1(input logic [63:0] d, input logic f);
        we = 1'b1;
        wdata = d;
        flag = f;
        step();
        we = 1'b0;
        flag = 1'b0;
    endtask

    task automatic drain_wait(input int budget);
        int k = 0;
        while ((count_o[0] != 9'd0 || en_o[0] || dbg_o[0] != ST_IDLE) && k < budget) begin
            step();
            k++;
        end
        check("drain_timeout", 64'(k < budget), 64'd1);
        step();
    endtask

    // ---------------- directed tests ----------------
    int words, gaps, early, commit_at74;

    initial begin
        do_reset();
        step();

        // single entry, flag set
        @(negedge clk);
        check("single_cnt_before", 64'(count_o[0]), 64'd0);
        check("single_commit_before", 64'(commit_o[0]), 64'd0);
        push1(64'h1122334455667788, 1'b1);
        @(negedge clk);
        check("single_cnt_t1", 64'(count_o[0]), 64'd1);
        check("single_en_t1", 64'(en_o[0]), 64'd0);
        step();
        @(negedge clk);
        check("single_en_t2", 64'(en_o[0]), 64'd0);
        step();
        @(negedge clk);
        check("single_lo_addr", 64'(addr_o[0]), 64'd0);
        check("single_lo_din", 64'(din_o[0]), 64'h55667788);
        check("single_lo_commit", 64'(commit_o[0]), 64'd0);
        step();
        @(negedge clk);
        check("single_hi_addr", 64'(addr_o[0]), 64'd4);
        check("single_hi_din", 64'(din_o[0]), 64'h11223344);
        check("single_hi_cnt", 64'(count_o[0]), 64'd0);
        check("single_hi_commit", 64'(commit_o[0]), 64'd2);

        // 37-entry packet, flag on the last entry only
        do_reset();
        step();
        words = 0; gaps = 0; early = 0; commit_at74 = -1;
        fork
            begin
                for (int i = 0; i < 37; i++) begin
                    we = 1'b1;
                    wdata = {32'h5000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
                    flag = (i == 36);
                    step();
                end
                we = 1'b0;
                flag = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && words < 74; c++) begin
                    @(negedge clk);
                    if (en_o[0]) words++;
                    else if (words > 0) gaps++;
                    if (words == 74) commit_at74 = int'(commit_o[0]);
                    else if (commit_o[0] != 14'd0) early++;
                end
            end
        join
        check("pkt_words", 64'(words), 64'd74);
        check("pkt_gaps", 64'(gaps), 64'd0);
        check("pkt_early_commit", 64'(early), 64'd0);
        check("pkt_commit", 64'(commit_at74), 64'd74);
        check("pkt_commit_wrap8", 64'(commit_o[1]), 64'd2);
        drain_wait(50);

        // five flagged entries: the 8-word instance wraps to 0..1
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            we = 1'b1;
            wdata = {32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
            flag = 1'b1;
            step();
        end
        we = 1'b0;
        flag = 1'b0;
        drain_wait(100);
        @(negedge clk);
        check("wrap_commit8", 64'(commit_o[1]), 64'd2);
        check("wrap_commit_main", 64'(commit_o[0]), 64'd10);

        // continuous pushes until full; drops while full
        do_reset();
        step();
        for (int i = 0; i < 520; i++) begin
            we = 1'b1;
            wdata = 64'hCAFE_0000_0000_0000 | 64'(i);
            step();
            @(negedge clk);
            if (i == 0) check("fill_cnt_e0", 64'(count_o[0]), 64'd1);
            if (i == 3) check("fill_pushpop_cnt3", 64'(count_o[0]), 64'd3);
            if (i == 508) begin
                check("fill_full", 64'(full_o[0]), 64'd1);
                check("fill_cnt256", 64'(count_o[0]), 64'd256);
            end
            if (i == 509) begin
                check("fill_drop_full", 64'(full_o[0]), 64'd0);
                check("fill_drop_cnt", 64'(count_o[0]), 64'd255);
            end
        end
        we = 1'b0;
        drain_wait(1200);

        // reset between WR_LO and WR_HI
        push1(64'h0000_0001_0000_0002, 1'b1);
        drain_wait(20);
        push1(64'h7777_6666_5555_4444, 1'b0);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        check("rstmid_lo_en", 64'(en_o[0]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_en", 64'(en_o[0]), 64'd0);
        check("rstmid_addr", 64'(addr_o[0]), 64'd0);
        check("rstmid_cnt", 64'(count_o[0]), 64'd0);
        check("rstmid_commit", 64'(commit_o[0]), 64'd0);
        push1(64'hDEAD_BEEF_0123_4567, 1'b1);
        step();
        step();
        @(negedge clk);
        check("rstmid_new_addr", 64'(addr_o[0]), 64'd0);
        check("rstmid_new_din", 64'(din_o[0]), 64'h0123_4567);
        drain_wait(20);
        @(negedge clk);
        check("rstmid_new_commit", 64'(commit_o[0]), 64'd2);
        check("leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
